div_sequencer: RTL
==================

// Module: div_sequencer
// PURPOSE
//  Sequential controller for the unsigned shift-subtract (restoring) divider.
//  Accepts a start request with dividend/divisor and runs one quotient bit per clock.
//  Publishes a registered quotient/remainder pair, held stable between operations
//  and fed directly to the 7-segment display controller.
//  Sits between the board switch/button inputs and the display path.
// PARAMETERS
//  WIDTH  8  operand, quotient and remainder width in bits; must be >= 2
// PORTS
//  clock_100Mhz  in   1      100 MHz system clock; all logic on rising edge
//  reset         in   1      synchronous, active-high; sampled on clock_100Mhz edge
//  start         in   1      request to begin a division
//  dividend      in   WIDTH  numerator; sampled only when start is accepted
//  divisor       in   WIDTH  denominator; sampled only when start is accepted
//  busy          out  1      high while an operation is in progress (CALC or FINISH)
//  done          out  1      one-cycle pulse; quotient/remainder updated this cycle
//  div_by_zero   out  1      high if the last completed operation had divisor==0
//  quotient      out  WIDTH  registered result; held until the next completion
//  remainder     out  WIDTH  registered result; held until the next completion
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0;
//   iteration counter and working registers cleared. Reset in any state, including
//   mid-operation, aborts the operation with no done pulse.
//  FSM: IDLE, CALC, FINISH.
//  IDLE: start_req=1 at an edge -> latch A=0, Q=dividend, M=divisor, cnt=0.
//   If divisor!=0 go to CALC, else go to FINISH with z flag set.
//  CALC: each edge: {A,Q} <<= 1; if A>=M then A-=M and Q[0]=1; cnt++.
//   Compare/subtract in WIDTH+1 bits. After the WIDTH-th iteration go to FINISH.
//  FINISH: one edge -> quotient=Q, remainder=A, div_by_zero=z, done=1, go to IDLE.
//   On z: quotient={WIDTH{1}} (0xFF for WIDTH=8), remainder=dividend.
//  Latency:
//   - Normal: done rises WIDTH+1 edges after the accepting edge (9 for WIDTH=8).
//   - Divide-by-zero: done rises 1 edge after the accepting edge.
//  busy=1 in CALC and FINISH; done is never high on two consecutive cycles.
//  start during CALC/FINISH: ignored, with no queuing.
//   start in the IDLE cycle right after done: accepted normally.
//  dividend/divisor changes during CALC: no effect, because operands are latched.
//  div_by_zero remains valid until the next completion overwrites it.
// CONFIGURATION
//  BUTTON_SYNC_EN defined: start passes through a 2-flop synchronizer plus a
//   rising-edge detector. start_req = sync & ~sync_d. A held button yields exactly
//   one operation. Acceptance is delayed by 2 cycles relative to raw start.
//  BUTTON_SYNC_EN undefined: start_req=start (level). Holding start high
//   re-launches an operation on every IDLE cycle.
// STRUCTURE
//  div_pkg:
//   - typedef enum logic [1:0] {IDLE, CALC, FINISH} div_state_t;
//   - localparam DIV_WIDTH_DEFAULT = 8.
//  Sub-module div_step (combinational): inputs A, Q, M;
//   outputs the next A and Q for one restoring iteration.
//  Top level holds the FSM, counter ($clog2(WIDTH+1) bits), working and output registers.
// TESTING
//  1. 200/7, start for 1 cycle -> busy for 9 cycles; done pulse;
//     quotient=28, remainder=4, div_by_zero=0.
//  2. 5/0 -> done 1 edge after accept; quotient=0xFF, remainder=5, div_by_zero=1.
//     Follow with 9/3 -> quotient=3, remainder=0, div_by_zero cleared.
//  3. 255/1 then 3/10 -> (255,0) then (0,3). Outputs stay stable between the done pulses.
//  4. Start 100/9; pulse start with 50/2 at the 3rd CALC cycle -> second start ignored;
//     result (11,1); exactly one done pulse.
//  5. Assert reset at the 4th CALC cycle of 200/7 -> all outputs 0, no done.
//     A new 17/4 after reset -> (4,1).
//  6. Hold start high for 30 cycles:
//     - BUTTON_SYNC_EN defined: exactly 1 done.
//     - BUTTON_SYNC_EN undefined: a done every 10 cycles (WIDTH+2).

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and defaults for the shift-subtract divider.
//   div_state_t        : controller states (IDLE, CALC, FINISH)
//   DIV_WIDTH_DEFAULT  : default operand/result width
`timescale 1ns/1ps
package div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FINISH} div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/div_step.sv
// One iteration of the unsigned restoring divider (purely combinational).
// Ports:
//   a      in   WIDTH  partial remainder before this iteration
//   q      in   WIDTH  dividend/quotient shift register before this iteration
//   m      in   WIDTH  divisor
//   a_next out  WIDTH  partial remainder after shift and conditional subtract
//   q_next out  WIDTH  shift register with the new quotient bit in bit 0
`timescale 1ns/1ps
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] q_next
);

    // {A,Q} shifted left by one; the top bit of A moves into bit WIDTH,
    // so the compare must be WIDTH+1 bits wide.
    logic [WIDTH:0] partial;

    always_comb begin
        partial = {a, q[WIDTH-1]};
        if (partial >= {1'b0, m}) begin
            // The difference is always below m, so the low WIDTH bits are exact.
            a_next = partial[WIDTH-1:0] - m;
            q_next = {q[WIDTH-2:0], 1'b1};
        end else begin
            a_next = partial[WIDTH-1:0];
            q_next = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Sequential controller for an unsigned restoring divider: one quotient bit
// per clock, registered results held stable for the display path.
// Optional build macro: BUTTON_SYNC_EN -- start goes through a 2-flop
// synchronizer and rising-edge detector so a held button launches one
// operation; otherwise start is a level request.
// Ports:
//   clock_100Mhz in   1      system clock, rising edge
//   reset        in   1      synchronous, active-high
//   start        in   1      request to begin a division
//   dividend     in   WIDTH  numerator, sampled when start is accepted
//   divisor      in   WIDTH  denominator, sampled when start is accepted
//   busy         out  1      operation in progress (CALC or FINISH)
//   done         out  1      one-cycle pulse when results update
//   div_by_zero  out  1      last completed operation had divisor == 0
//   quotient     out  WIDTH  registered quotient
//   remainder    out  WIDTH  registered remainder
`timescale 1ns/1ps
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clock_100Mhz,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int              CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_t       state;
    div_state_t       state_next;
    logic             start_req;
    logic             load;
    logic             step;
    logic             publish;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CNT_W-1:0] cnt;
    logic             zero_flag;
    logic [WIDTH-1:0] a_step;
    logic [WIDTH-1:0] q_step;

`ifdef BUTTON_SYNC_EN
    logic start_sync1;
    logic start_sync2;
    logic start_sync2_d;

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            start_sync1   <= 1'b0;
            start_sync2   <= 1'b0;
            start_sync2_d <= 1'b0;
        end else begin
            start_sync1   <= start;
            start_sync2   <= start_sync1;
            start_sync2_d <= start_sync2;
        end
    end

    // Rising edge only: a held button produces a single request.
    assign start_req = start_sync2 & ~start_sync2_d;
`else
    assign start_req = start;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a      (a_reg),
        .q      (q_reg),
        .m      (m_reg),
        .a_next (a_step),
        .q_next (q_step)
    );

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        publish    = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_req) begin
                    load = 1'b1;
                    // A zero divisor skips the iterations entirely.
                    state_next = (divisor != '0) ? CALC : FINISH;
                end
            end
            CALC: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LAST_ITER) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                busy       = 1'b1;
                publish    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            a_reg       <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            cnt         <= '0;
            zero_flag   <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            done <= publish;
            if (load) begin
                a_reg     <= '0;
                q_reg     <= dividend;
                m_reg     <= divisor;
                cnt       <= '0;
                zero_flag <= (divisor == '0);
            end
            if (step) begin
                a_reg <= a_step;
                q_reg <= q_step;
                cnt   <= cnt + 1'b1;
            end
            if (publish) begin
                div_by_zero <= zero_flag;
                if (zero_flag) begin
                    // q_reg still holds the untouched dividend on this path.
                    quotient  <= '1;
                    remainder <= q_reg;
                end else begin
                    quotient  <= q_reg;
                    remainder <= a_reg;
                end
            end
        end
    end

endmodule
